// File: rtl/uart_frame_sequencer_pkg.sv
// Shared constants and FSM encoding for the UART frame sequencer.
// ASCII codes used to build the per-channel voltage text lines.
package uart_frame_sequencer_pkg;

  localparam int BYTES_PER_CH = 12;

  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] VOLT  = 8'h56;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/uart_frame_sequencer_bcd_line_formatter.sv
// Combinational lookup of one ASCII byte of a channel line "Cnn:d.dddV\r\n".
// Non-decimal nibbles are rendered as '?' so corrupted samples stay visible.
module bcd_line_formatter
  import uart_frame_sequencer_pkg::*;
(
  input  logic [15:0] bcd_i,
  input  logic [6:0]  ch_i,
  input  logic [3:0]  idx_i,
  output logic [7:0]  byte_o
);

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    if (n > 4'd9) begin
      return QMARK;
    end else begin
      return ZERO + {4'h0, n};
    end
  endfunction

  logic [3:0] tens_s;
  logic [3:0] ones_s;

  assign tens_s = 4'(ch_i / 7'd10);
  assign ones_s = 4'(ch_i % 7'd10);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      4'd0:    byte_o = CH_C;
      4'd1:    byte_o = nib2asc(tens_s);
      4'd2:    byte_o = nib2asc(ones_s);
      4'd3:    byte_o = COLON;
      4'd4:    byte_o = nib2asc(bcd_i[15:12]);
      4'd5:    byte_o = DOT;
      4'd6:    byte_o = nib2asc(bcd_i[11:8]);
      4'd7:    byte_o = nib2asc(bcd_i[7:4]);
      4'd8:    byte_o = nib2asc(bcd_i[3:0]);
      4'd9:    byte_o = VOLT;
      4'd10:   byte_o = CR;
      4'd11:   byte_o = LF;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Periodic snapshot of all BCD channels, serialised as ASCII lines into the UART TX FIFO.
// Each write is followed by an idle cycle so tx_full reflects the previous write.
module uart_frame_sequencer
  import uart_frame_sequencer_pkg::*;
#(
  parameter int NCH        = 13,
  parameter int PERIOD_CYC = 6_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [16*NCH-1:0] bcd_flat,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  localparam int TW = $clog2(PERIOD_CYC);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e                 state_q;
  logic [TW-1:0]          timer_q;
  logic [TW-1:0]          timer_d;
  logic                   tick_s;
  logic [NCH-1:0][15:0]   snap_q;
  logic [CW-1:0]          ch_q;
  logic [3:0]             idx_q;
  logic                   wr_uart_q;
  logic [7:0]             w_data_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [7:0]             frame_cnt_q;
  logic [7:0]             byte_s;

  assign tick_s = (timer_q == TW'(0));

  always_comb begin
    timer_d = timer_q;
    if (tick_s) begin
      timer_d = TW'(PERIOD_CYC - 1);
    end else begin
      timer_d = timer_q - TW'(1);
    end
  end

  // Frame timer runs regardless of enable or FIFO stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= TW'(PERIOD_CYC - 1);
    end else begin
      timer_q <= timer_d;
    end
  end

  bcd_line_formatter u_fmt (
    .bcd_i  (snap_q[ch_q]),
    .ch_i   (7'(ch_q)),
    .idx_i  (idx_q),
    .byte_o (byte_s)
  );

  // Frame FSM with registered strobe, data and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      ch_q        <= CW'(0);
      idx_q       <= 4'd0;
      wr_uart_q   <= 1'b0;
      w_data_q    <= 8'h00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      if (tick_s && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else begin
        overrun_q <= overrun_q;
      end
      case (state_q)
        IDLE: begin
          if (tick_s && enable) begin
            state_q <= SNAP;
          end else begin
            state_q <= IDLE;
          end
        end
        SNAP: begin
          snap_q  <= bcd_flat;
          ch_q    <= CW'(0);
          idx_q   <= 4'd0;
          busy_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (!tx_full) begin
            wr_uart_q <= 1'b1;
            w_data_q  <= byte_s;
            state_q   <= GAP;
          end else begin
            wr_uart_q <= 1'b0;
          end
        end
        GAP: begin
          wr_uart_q <= 1'b0;
          if (idx_q == 4'(BYTES_PER_CH - 1)) begin
            idx_q <= 4'd0;
            if (ch_q == CW'(NCH - 1)) begin
              state_q <= DONE;
            end else begin
              ch_q    <= ch_q + CW'(1);
              state_q <= SEND;
            end
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= SEND;
          end
        end
        DONE: begin
          busy_q      <= 1'b0;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          state_q     <= IDLE;
        end
        default: begin
          wr_uart_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign wr_uart   = wr_uart_q;
  assign w_data    = w_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench: captures the byte stream and compares against hand-written lines and a text model.
module tb_uart_frame_sequencer;

  localparam int NCH = 13;
  localparam int PER = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              tx_full = 1'b0;
  logic [16*NCH-1:0] bcd_flat;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic              overrun;
  logic [7:0]        frame_cnt;

  logic [15:0] vals [NCH];
  logic [15:0] snap1 [NCH];
  logic [7:0]  cap [$];
  int          scyc [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  uart_frame_sequencer #(.NCH(NCH), .PERIOD_CYC(PER)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bcd_flat  (bcd_flat),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    bcd_flat = '0;
    for (int k = 0; k < NCH; k++) bcd_flat[16*k +: 16] = vals[k];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_uart) begin
      cap.push_back(w_data);
      scyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bytes(input int n, input int max);
    int c = 0;
    while (cap.size() < n && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic wait_cnt(input logic [7:0] t, input int max);
    int c = 0;
    while (frame_cnt != t && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  function automatic logic [95:0] line_of(input int base);
    logic [95:0] r = '0;
    for (int i = 0; i < 12; i++) begin
      if (base + i < cap.size()) r = {r[87:0], cap[base+i]};
      else r = {r[87:0], 8'h00};
    end
    return r;
  endfunction

  function automatic string dg(input logic [3:0] n);
    if (n <= 4'd9) return $sformatf("%0d", n);
    else return "?";
  endfunction

  function automatic int stream_errs(input logic [15:0] v [NCH]);
    int e = 0;
    string ln;
    if (cap.size() != 12*NCH) e++;
    for (int k = 0; k < NCH; k++) begin
      ln = $sformatf("C%02d:%s.%s%s%sV\r\n", k, dg(v[k][15:12]), dg(v[k][11:8]),
                     dg(v[k][7:4]), dg(v[k][3:0]));
      for (int i = 0; i < 12; i++) begin
        if (12*k + i >= cap.size()) e++;
        else if (cap[12*k+i] != ln[i]) e++;
      end
    end
    return e;
  endfunction

  function automatic int spacing_errs();
    int e = 0;
    for (int i = 1; i < scyc.size(); i++) if (scyc[i] - scyc[i-1] != 2) e++;
    return e;
  endfunction

  initial begin
    for (int k = 0; k < NCH; k++) vals[k] = 16'h0000;
    vals[0] = 16'h1234;
    vals[3] = 16'h1A34;
    vals[5] = 16'h0500;
    for (int k = 0; k < NCH; k++) snap1[k] = vals[k];

    cycles(3);
    check_val("reset_outputs", 128'({wr_uart, w_data, busy, overrun, frame_cnt}), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;

    // Frame 1: mid-frame data change and a 50-cycle FIFO stall at byte 30.
    wait_bytes(10, 1000);
    vals[5] = 16'h0999;
    wait_bytes(30, 200);
    tx_full = 1'b1;
    cycles(50);
    check_val("stall_no_write", 128'(cap.size()), 128'(30));
    tx_full = 1'b0;
    wait_cnt(8'd1, 1000);
    check_val("f1_frame_cnt", 128'(frame_cnt), 128'(1));
    check_val("f1_busy_low", 128'(busy), 128'(0));
    check_val("f1_bytes", 128'(cap.size()), 128'(156));
    check_val("f1_line0", 128'(line_of(0)), 128'("C00:1.234V\r\n"));
    check_val("f1_line2", 128'(line_of(24)), 128'("C02:0.000V\r\n"));
    check_val("f1_line3_qmark", 128'(line_of(36)), 128'("C03:1.?34V\r\n"));
    check_val("f1_line5_snap", 128'(line_of(60)), 128'("C05:0.500V\r\n"));
    check_val("f1_line12", 128'(line_of(144)), 128'("C12:0.000V\r\n"));
    check_val("f1_stream", 128'(stream_errs(snap1)), 128'(0));
    check_val("f1_no_overrun", 128'(overrun), 128'(0));

    // Frame 2: unstalled spacing, new ch5 value, enable dropped mid-frame.
    cap.delete();
    scyc.delete();
    wait_bytes(20, 1000);
    enable = 1'b0;
    wait_cnt(8'd2, 1000);
    check_val("f2_frame_cnt", 128'(frame_cnt), 128'(2));
    check_val("f2_bytes", 128'(cap.size()), 128'(156));
    check_val("f2_line5_new", 128'(line_of(60)), 128'("C05:0.999V\r\n"));
    check_val("f2_spacing", 128'(spacing_errs()), 128'(0));
    check_val("f2_stream", 128'(stream_errs(vals)), 128'(0));
    cycles(900);
    check_val("disabled_cnt", 128'(frame_cnt), 128'(2));
    check_val("disabled_bytes", 128'(cap.size()), 128'(156));

    // Frame 3: stall long enough that a tick lands inside the frame.
    enable = 1'b1;
    cap.delete();
    scyc.delete();
    wait_bytes(40, 1000);
    tx_full = 1'b1;
    cycles(200);
    tx_full = 1'b0;
    wait_cnt(8'd3, 1000);
    check_val("f3_frame_cnt", 128'(frame_cnt), 128'(3));
    check_val("f3_overrun", 128'(overrun), 128'(1));
    check_val("f3_bytes", 128'(cap.size()), 128'(156));
    check_val("f3_stream", 128'(stream_errs(vals)), 128'(0));
    cycles(2);
    check_val("f3_no_restart", 128'(busy), 128'(0));

    // Frame 4: asynchronous reset in the middle of the frame.
    cap.delete();
    wait_bytes(70, 1000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rst_mid_wr", 128'(wr_uart), 128'(0));
    check_val("rst_mid_busy", 128'(busy), 128'(0));
    check_val("rst_mid_cnt", 128'(frame_cnt), 128'(0));
    check_val("rst_mid_ovr", 128'(overrun), 128'(0));
    cycles(3);
    @(negedge clk);
    rst = 1'b1;
    cap.delete();
    wait_cnt(8'd1, 1000);
    check_val("post_rst_cnt", 128'(frame_cnt), 128'(1));
    check_val("post_rst_line0", 128'(line_of(0)), 128'("C00:1.234V\r\n"));
    check_val("post_rst_stream", 128'(stream_errs(vals)), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
